// File: rtl/lcd_timing_gen.sv
// Parallel-RGB LCD timing generator: free-running h/v raster counters feeding a
// two-stage pipeline (pixel request, then DE/sync/RGB aligned with returned pixel).
module lcd_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 29,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        PixelClk,
  input  logic        nRST,
  input  logic        en,
  input  logic [15:0] rgb_in,
  output logic        pix_req,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        frame_start,
  output logic        LCD_DE,
  output logic        LCD_HSYNC,
  output logic        LCD_VSYNC,
  output logic [4:0]  LCD_R,
  output logic [5:0]  LCD_G,
  output logic [4:0]  LCD_B
);

  // Totals beyond 2048 clocks per line or 1024 lines per frame do not fit the counters.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        h_wrap, v_wrap;
  logic        h_act, v_act, h_sync, v_sync;
  logic        hsync_s1, vsync_s1;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);
  assign h_act  = (h_cnt < H_ACT_END);
  assign v_act  = (v_cnt < V_ACT_END);
  assign h_sync = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign v_sync = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

  // Counters sit at (0,0) while disabled so the first enabled edge starts a frame.
  always_ff @(posedge PixelClk) begin
    if (!nRST || !en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  always_ff @(posedge PixelClk) begin
    if (!nRST || !en) begin
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      hsync_s1    <= 1'b0;
      vsync_s1    <= 1'b0;
    end else begin
      pix_req     <= h_act && v_act;
      pix_x       <= (h_act && v_act) ? h_cnt[9:0] : '0;
      pix_y       <= (h_act && v_act) ? v_cnt[8:0] : '0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      hsync_s1    <= h_sync;
      vsync_s1    <= v_sync;
    end
  end

  // rgb_in answers the request held in stage 1, so both are captured on the same edge.
  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      LCD_DE    <= 1'b0;
      LCD_R     <= '0;
      LCD_G     <= '0;
      LCD_B     <= '0;
      LCD_HSYNC <= ~SYNC_POL;
      LCD_VSYNC <= ~SYNC_POL;
    end else begin
      LCD_DE    <= pix_req;
      LCD_R     <= pix_req ? rgb_in[15:11] : '0;
      LCD_G     <= pix_req ? rgb_in[10:5]  : '0;
      LCD_B     <= pix_req ? rgb_in[4:0]   : '0;
      LCD_HSYNC <= hsync_s1 ? SYNC_POL : ~SYNC_POL;
      LCD_VSYNC <= vsync_s1 ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 128, HSYNC width (clocks)
- H_BP, 88, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 13, vertical front porch (lines)
- V_SYNC, 3, VSYNC width (lines)
- V_BP, 29, vertical back porch (lines)
- SYNC_POL, 0, asserted level of LCD_HSYNC/LCD_VSYNC (0 = active-low)
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- PixelClk, input, 1, 40 MHz pixel clock from the PLL; sole clock
- nRST, input, 1, synchronous active-low reset
- en, input, 1, timing run enable
- rgb_in, input, 16, RGB565 pixel for the previous cycle's request
- pix_req, output, 1, pixel request for coordinate pix_x/pix_y
- pix_x, output, 10, requested column
- pix_y, output, 9, requested row
- frame_start, output, 1, one-cycle pulse with the request for pixel (0,0)
- LCD_DE, output, 1, data enable
- LCD_HSYNC, output, 1, horizontal sync
- LCD_VSYNC, output, 1, vertical sync
- LCD_R, output, 5, red
- LCD_G, output, 6, green
- LCD_B, output, 5, blue
REQ-003 The single clock SHALL be PixelClk; reset SHALL be nRST, synchronous, active-low; no other clock or async logic.

Function
REQ-004 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1056) and wrap to 0; v_cnt SHALL count 0..V_TOTAL-1 (525), incrementing only when h_cnt wraps, and wrap to 0 when both wrap together.
REQ-005 Line regions by h_cnt: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) = [840,968), back porch; frame regions likewise by v_cnt: active [0,480), sync [493,496).
REQ-006 Stage 1 (registered from counters): pix_req = h active AND v active; pix_x = h_cnt, pix_y = v_cnt when pix_req, else 0; frame_start = 1 when h_cnt = 0 and v_cnt = 0.
REQ-007 Stage 2 (registered from stage 1 and rgb_in): LCD_DE = delayed pix_req; LCD_R/G/B = rgb_in[15:11]/[10:5]/[4:0] when delayed pix_req, else 0; LCD_HSYNC/LCD_VSYNC = SYNC_POL while the counters of the corresponding pixel were in sync region, else ~SYNC_POL.
REQ-008 Latency: counter value -> pix_req 1 cycle; pix_req -> LCD_DE with that pixel's data 1 cycle; syncs and DE SHALL stay mutually aligned (all 2 cycles after counters).
REQ-009 Upstream SHALL present rgb_in exactly one cycle after the pix_req it answers; the block SHALL NOT stall or apply back-pressure.
REQ-010 en low: counters SHALL load 0 and hold; stage 1 SHALL register pix_req=0, frame_start=0, syncs deasserted; stage 2 flushes within 2 cycles to DE=0, syncs deasserted, RGB=0.
REQ-011 en rising: first cycle with en high SHALL evaluate counters (0,0), so frame_start pulses one cycle later and a full frame begins.
REQ-012 Counter widths: h_cnt 11 bits, v_cnt 10 bits; no overflow for defaults; parameters with H_TOTAL > 2048 or V_TOTAL > 1024 are unsupported.

Reset
REQ-013 nRST low on a PixelClk edge SHALL clear h_cnt, v_cnt, pix_req, pix_x, pix_y, frame_start, LCD_DE, LCD_R/G/B to 0 and drive LCD_HSYNC/LCD_VSYNC to ~SYNC_POL, including mid-line or mid-frame.
REQ-014 After nRST release with en high, behaviour SHALL be identical to REQ-011.

Verification
REQ-015 Reset release, en=1 -> frame_start high at cycle 1 only; LCD_DE first high at cycle 2; per line exactly 800 DE cycles then 256 low; frame_start period 554400 cycles.
REQ-016 Sync check -> LCD_HSYNC low 128 cycles starting 842 cycles after frame_start-aligned counter 0 (840+2); LCD_VSYNC low 3 lines from line 493; 45 DE-free lines per frame.
REQ-017 rgb_in driven as registered function {x[4:0],y[5:0],x[9:5]} of pix_x/pix_y -> LCD_R/G/B match expected pixel on every DE cycle, zero when DE low.
REQ-018 en dropped at h_cnt=400, v_cnt=100, held 10 cycles, raised -> DE low within 2 cycles, syncs inactive, frame_start 1 cycle after en high, then full frame.
REQ-019 nRST pulsed low 1 cycle mid-VSYNC -> all outputs at reset values next cycle; restart per REQ-015.
REQ-020 SYNC_POL=1 build -> sync pulses high, same timing as REQ-016.
